gain_sc16_core: RTL and testbench

GAIN_SC16_CORE -- requirements
Module: gain_sc16_core

---
 rtl/gain_oot_pkg.sv | 17 +
 rtl/gain_sc16_round_sat.sv | 39 +++
 rtl/gain_sc16_core.sv | 158 +++++++++++++++
 tb/tb_gain_sc16_core.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gain_oot_pkg.sv
// Shared types and constants for the sc16 gain block: IQ packing, clamp limits
// and the unity-gain value for a given number of fractional gain bits.
package gain_oot_pkg;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } sc16_t;

  localparam int SC16_MAX = 32767;
  localparam int SC16_MIN = -32768;

  function automatic longint unity_gain(input int frac);
    return longint'(1) << frac;
  endfunction

endpackage

// File: rtl/gain_sc16_round_sat.sv
// Round-half-up and clamp of one full-precision product back to a signed 16-bit
// sample; sat flags when the clamp was applied.
module gain_sc16_round_sat
  import gain_oot_pkg::*;
#(
  parameter int PROD_W = 32,
  parameter int FRAC   = 8
) (
  input  logic signed [PROD_W-1:0] prod,
  output logic signed [15:0]       y,
  output logic                     sat
);

  // One guard bit keeps the half-LSB addition from overflowing.
  localparam logic signed [PROD_W:0] HALF = (PROD_W+1)'(1) << (FRAC-1);
  localparam logic signed [PROD_W:0] MAXV = (PROD_W+1)'(SC16_MAX);
  localparam logic signed [PROD_W:0] MINV = (PROD_W+1)'(SC16_MIN);

  function automatic logic signed [PROD_W:0] round_half_up(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W:0] s;
    s = $signed({p[PROD_W-1], p}) + HALF;
    return s >>> FRAC;
  endfunction

  function automatic logic signed [15:0] saturate(input logic signed [PROD_W:0] v);
    if (v > MAXV) return 16'(SC16_MAX);
    if (v < MINV) return 16'(SC16_MIN);
    return v[15:0];
  endfunction

  logic signed [PROD_W:0] rnd;

  always_comb begin
    rnd = round_half_up(prod);
    y   = saturate(rnd);
    sat = (rnd > MAXV) || (rnd < MINV);
  end

endmodule

// File: rtl/gain_sc16_core.sv
// Three-stage sc16 gain: register, multiply, round/saturate, one global stall.
// Optional GAIN_SAT_COUNT_EN adds the sat_count port counting clamped beats.
module gain_sc16_core
  import gain_oot_pkg::*;
#(
  parameter int GAIN_W    = 16,
  parameter int GAIN_FRAC = 8
) (
  input  logic              rfnoc_chdr_clk,
  input  logic              rfnoc_chdr_rst_n,
  input  logic [GAIN_W-1:0] gain,
  input  logic [31:0]       s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready
`ifdef GAIN_SAT_COUNT_EN
  , output logic [31:0]     sat_count
`endif
);

  localparam int PROD_W = 16 + GAIN_W;
  localparam logic signed [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_FRAC));

  logic ce, accept;
  logic first_q, first_d;
  logic signed [GAIN_W-1:0] gain_lat_q, gain_lat_d, gain_beat;

  logic vld_p0_q, vld_p0_d, last_p0_q, last_p0_d;
  sc16_t x_p0_q, x_p0_d;
  logic signed [GAIN_W-1:0] g_p0_q, g_p0_d;

  logic vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;
  logic signed [PROD_W-1:0] prod_i_p1_q, prod_i_p1_d, prod_q_p1_q, prod_q_p1_d;

  logic vld_p2_q, vld_p2_d, last_p2_q, last_p2_d;
  sc16_t y_p2_q, y_p2_d;

  logic signed [15:0] y_i, y_q;
  logic sat_i, sat_q;

`ifdef GAIN_SAT_COUNT_EN
  logic [31:0] sat_cnt_q, sat_cnt_d;
`else
  logic sat_unused;
  assign sat_unused = sat_i | sat_q;
`endif

  gain_sc16_round_sat #(.PROD_W(PROD_W), .FRAC(GAIN_FRAC)) u_rs_i (
    .prod (prod_i_p1_q),
    .y    (y_i),
    .sat  (sat_i)
  );

  gain_sc16_round_sat #(.PROD_W(PROD_W), .FRAC(GAIN_FRAC)) u_rs_q (
    .prod (prod_q_p1_q),
    .y    (y_q),
    .sat  (sat_q)
  );

  always_comb begin
    ce        = !vld_p2_q || m_axis_tready;
    accept    = s_axis_tvalid && ce;
    gain_beat = first_q ? $signed(gain) : gain_lat_q;

    first_d     = first_q;
    gain_lat_d  = gain_lat_q;
    vld_p0_d    = vld_p0_q;
    last_p0_d   = last_p0_q;
    x_p0_d      = x_p0_q;
    g_p0_d      = g_p0_q;
    vld_p1_d    = vld_p1_q;
    last_p1_d   = last_p1_q;
    prod_i_p1_d = prod_i_p1_q;
    prod_q_p1_d = prod_q_p1_q;
    vld_p2_d    = vld_p2_q;
    last_p2_d   = last_p2_q;
    y_p2_d      = y_p2_q;
`ifdef GAIN_SAT_COUNT_EN
    sat_cnt_d   = sat_cnt_q;
`endif

    if (accept) begin
      first_d    = s_axis_tlast;
      gain_lat_d = gain_beat;
    end

    if (ce) begin
      // p0: capture input beat with the gain that applies to its packet
      vld_p0_d    = s_axis_tvalid;
      last_p0_d   = s_axis_tvalid && s_axis_tlast;
      x_p0_d      = s_axis_tdata;
      g_p0_d      = gain_beat;
      // p1: full-precision products
      vld_p1_d    = vld_p0_q;
      last_p1_d   = last_p0_q;
      prod_i_p1_d = PROD_W'(x_p0_q.i) * PROD_W'(g_p0_q);
      prod_q_p1_d = PROD_W'(x_p0_q.q) * PROD_W'(g_p0_q);
      // p2: rounded, clamped output beat
      vld_p2_d    = vld_p1_q;
      last_p2_d   = last_p1_q;
      y_p2_d      = '{i: y_i, q: y_q};
`ifdef GAIN_SAT_COUNT_EN
      if (vld_p1_q && (sat_i || sat_q) && (sat_cnt_q != 32'hFFFF_FFFF))
        sat_cnt_d = sat_cnt_q + 32'd1;
`endif
    end
  end

  always_ff @(posedge rfnoc_chdr_clk or negedge rfnoc_chdr_rst_n) begin
    if (!rfnoc_chdr_rst_n) begin
      first_q    <= 1'b1;
      gain_lat_q <= UNITY;
      vld_p0_q   <= 1'b0;
      last_p0_q  <= 1'b0;
      vld_p1_q   <= 1'b0;
      last_p1_q  <= 1'b0;
      vld_p2_q   <= 1'b0;
      last_p2_q  <= 1'b0;
      y_p2_q     <= '0;
`ifdef GAIN_SAT_COUNT_EN
      sat_cnt_q  <= '0;
`endif
    end else begin
      first_q    <= first_d;
      gain_lat_q <= gain_lat_d;
      vld_p0_q   <= vld_p0_d;
      last_p0_q  <= last_p0_d;
      vld_p1_q   <= vld_p1_d;
      last_p1_q  <= last_p1_d;
      vld_p2_q   <= vld_p2_d;
      last_p2_q  <= last_p2_d;
      y_p2_q     <= y_p2_d;
`ifdef GAIN_SAT_COUNT_EN
      sat_cnt_q  <= sat_cnt_d;
`endif
    end
  end

  always_ff @(posedge rfnoc_chdr_clk) begin
    x_p0_q      <= x_p0_d;
    g_p0_q      <= g_p0_d;
    prod_i_p1_q <= prod_i_p1_d;
    prod_q_p1_q <= prod_q_p1_d;
  end

  assign s_axis_tready = ce;
  assign m_axis_tvalid = vld_p2_q;
  assign m_axis_tlast  = last_p2_q;
  assign m_axis_tdata  = y_p2_q;
`ifdef GAIN_SAT_COUNT_EN
  assign sat_count     = sat_cnt_q;
`endif

endmodule

// File: tb/tb_gain_sc16_core.sv
// Directed bench for gain_sc16_core (Q8.8 gain), with a short random-stall run.
module tb_gain_sc16_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] gain;
  logic [31:0] s_tdata;
  logic        s_tlast, s_tvalid, s_tready;
  logic [31:0] m_tdata;
  logic        m_tlast, m_tvalid, m_tready;
`ifdef GAIN_SAT_COUNT_EN
  logic [31:0] sat_count;
  logic [31:0] sat_base;
  int          exp_sat;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        l;
    logic [31:0] d;
  } beat_t;

  beat_t exp_q[$];
  beat_t got_q[$];

  always #5 clk = ~clk;

  gain_sc16_core dut (
    .rfnoc_chdr_clk   (clk),
    .rfnoc_chdr_rst_n (rst_n),
    .gain             (gain),
    .s_axis_tdata     (s_tdata),
    .s_axis_tlast     (s_tlast),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tready    (s_tready),
    .m_axis_tdata     (m_tdata),
    .m_axis_tlast     (m_tlast),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tready    (m_tready)
`ifdef GAIN_SAT_COUNT_EN
    , .sat_count      (sat_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Behavioural reference: {clamped, value} for one component
  function automatic logic [16:0] ref_c(input logic signed [15:0] x, input logic signed [15:0] g);
    longint p;
    p = (longint'(x) * longint'(g) + 128) >>> 8;
    if (p > 32767)  return {1'b1, 16'h7FFF};
    if (p < -32768) return {1'b1, 16'h8000};
    return {1'b0, p[15:0]};
  endfunction

  task automatic push_model(input logic [31:0] d, input logic [15:0] g, input logic l);
    logic [16:0] ri, rq;
    ri = ref_c(d[31:16], g);
    rq = ref_c(d[15:0], g);
    exp_q.push_back('{l: l, d: {ri[15:0], rq[15:0]}});
`ifdef GAIN_SAT_COUNT_EN
    if (ri[16] || rq[16]) exp_sat++;
`endif
  endtask

  task automatic push_exp(input logic [31:0] d, input logic l);
    exp_q.push_back('{l: l, d: d});
  endtask

  // Output monitor: collects beats and checks stability under backpressure
  logic  stall_prev = 1'b0;
  beat_t held;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, held.l, held.d}));
      if (m_tvalid && m_tready) got_q.push_back('{l: m_tlast, d: m_tdata});
      stall_prev <= m_tvalid && !m_tready;
      held       <= '{l: m_tlast, d: m_tdata};
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [31:0] d, input logic l, input bit rnd);
    int n;
    if (rnd) begin
      while ($urandom_range(3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    n = 0;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_tready) check("s_tready_timeout", 64'(s_tready), 64'd1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    beat_t e, g;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check(tag, 64'(g), 64'(e));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit done;
    int len;
    logic [15:0] g;
    logic [31:0] d;

    rst_n = 1'b0; gain = 16'h0100; s_tdata = '0; s_tlast = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
`ifdef GAIN_SAT_COUNT_EN
    exp_sat = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tlast",  64'(m_tlast),  64'd0);
    check("rst_tdata",  64'(m_tdata),  64'd0);
`ifdef GAIN_SAT_COUNT_EN
    check("rst_sat_count", 64'(sat_count), 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: single-beat packet, output appears on the third edge
    s_tvalid = 1'b1; s_tdata = 32'h1234_ABCD; s_tlast = 1'b1;
    push_exp(32'h1234_ABCD, 1'b1);
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    check("lat_e1_tvalid", 64'(m_tvalid), 64'd0);
    @(posedge clk); #1;
    check("lat_e2_tvalid", 64'(m_tvalid), 64'd0);
    @(posedge clk); #1;
    check("lat_e3_tvalid", 64'(m_tvalid), 64'd1);
    check("lat_e3_beat", 64'({m_tlast, m_tdata}), 64'({1'b1, 32'h1234_ABCD}));
    drain("single");

    // Unity gain ramp, 64 beats
    gain = 16'h0100;
    for (int n = 0; n < 64; n++) begin
      d = {16'(n), 16'(-n)};
      push_exp(d, n == 63);
      send(d, n == 63, 1'b0);
    end
    drain("ramp");

    // Saturation on I, exact -32768 on Q
`ifdef GAIN_SAT_COUNT_EN
    sat_base = sat_count;
`endif
    gain = 16'h0200;
    push_exp(32'h7FFF_8000, 1'b1);
    send(32'h4000_C000, 1'b1, 1'b0);
    drain("sat_x2");
`ifdef GAIN_SAT_COUNT_EN
    check("sat_count_x2", 64'(sat_count), 64'(sat_base + 32'd1));
`endif

    // Round-half-up: 3*0.5=1.5->2, -1.5->-1, -0.5->0, 0.5->1
    gain = 16'h0080;
    push_exp(32'h0002_FFFF, 1'b0);
    send(32'h0003_FFFD, 1'b0, 1'b0);
    push_exp(32'h0000_0001, 1'b1);
    send(32'hFFFF_0001, 1'b1, 1'b0);
    // Gain -1.0: -32768 clamps to 32767, 5 -> -5
    gain = 16'hFF00;
    push_exp(32'h7FFF_FFFB, 1'b1);
    send(32'h8000_0005, 1'b1, 1'b0);
    drain("round_neg");
`ifdef GAIN_SAT_COUNT_EN
    check("sat_count_neg", 64'(sat_count), 64'(sat_base + 32'd2));
`endif

    // Gain change mid-packet only takes effect at the next packet
    gain = 16'h0100;
    for (int n = 0; n < 64; n++) begin
      if (n == 10) gain = 16'h0300;
      d = {16'(n * 100), 16'(-n * 7)};
      push_exp(d, n == 63);
      send(d, n == 63, 1'b0);
    end
    for (int n = 0; n < 8; n++) begin
      push_exp({16'(n * 300), 16'(-n * 21)}, n == 7);
      send({16'(n * 100), 16'(-n * 7)}, n == 7, 1'b0);
    end
    drain("midgain");

    // Random stalls on both sides against the behavioural model
`ifdef GAIN_SAT_COUNT_EN
    sat_base = sat_count;
    exp_sat  = 0;
`endif
    done = 1'b0;
    fork
      begin
        for (int p = 0; p < 200; p++) begin
          len = $urandom_range(1, 8);
          g   = p[0] ? 16'($urandom) : (16'($urandom_range(0, 1023)) - 16'd512);
          gain = g;
          for (int b = 0; b < len; b++) begin
            d = $urandom;
            push_model(d, g, b == len - 1);
            send(d, b == len - 1, 1'b1);
            gain = 16'($urandom);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          m_tready = ($urandom_range(3) != 0);
        end
        m_tready = 1'b1;
      end
    join
    drain("stall");
`ifdef GAIN_SAT_COUNT_EN
    check("sat_count_stall", 64'(sat_count), 64'(sat_base + 32'(exp_sat)));
`endif

    // Reset mid-packet discards in-flight beats and restarts packet framing
    gain = 16'h0100;
    for (int n = 0; n < 5; n++) send({16'(n + 1), 16'(n + 1)}, 1'b0, 1'b0);
    check("pre_rst_tvalid", 64'(m_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_tdata",  64'({m_tlast, m_tdata}), 64'd0);
    exp_q.delete();
    got_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    gain = 16'h0200;
    for (int n = 0; n < 3; n++) begin
      push_exp({16'(2 * (n + 10)), 16'(-2 * (n + 10))}, n == 2);
      send({16'(n + 10), 16'(-(n + 10))}, n == 2, 1'b0);
      gain = 16'h0100;
    end
    drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
